// File: rtl/led_pio_sequencer_pkg.sv
// Shared types and field positions for the LED PIO sequencer.
// The PIO command word is {mode[1:0], arg[7:0]}; the mode selects how arg is
// turned into an LED pattern.
package led_seq_pkg;

   typedef enum logic [1:0] {
      M_DIRECT = 2'b00,
      M_BLINK  = 2'b01,
      M_CHASE  = 2'b10,
      M_PWM    = 2'b11
   } led_mode_t;

   localparam int MODE_MSB = 9;
   localparam int MODE_LSB = 8;
   localparam int ARG_MSB  = 7;
   localparam int CMD_W    = 10;
   localparam int LED_W    = 10;

   // One-position left rotate of the chase pattern; bit 9 wraps to bit 0.
   function automatic logic [LED_W-1:0] rotl1(input logic [LED_W-1:0] v);
      return {v[LED_W-2:0], v[LED_W-1]};
   endfunction

endpackage

// File: rtl/led_pio_sequencer_tick_gen.sv
// Pattern-tick prescaler.
//   clk_clk        in  system clock
//   reset_reset_n  in  asynchronous active-low reset
//   clr_i          in  synchronous restart of the count (new command)
//   tick_o         out high for the one cycle in which the count sits at TICK_DIV-1
module led_tick_gen #(
   parameter int TICK_DIV = 500000
) (
   input  logic clk_clk,
   input  logic reset_reset_n,
   input  logic clr_i,
   output logic tick_o
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TC = TW'(TICK_DIV - 1);

   logic [TW-1:0] tcnt_q, tcnt_d;

   assign tick_o = (tcnt_q == TC);

   always_comb begin
      tcnt_d = tcnt_q + TW'(1);
      if (clr_i || tick_o) begin
         tcnt_d = '0;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end

endmodule

// File: rtl/led_pio_sequencer.sv
// LED PIO sequencer: turns the static 10-bit HPS PIO command into a direct,
// blink, chase or PWM-dim pattern on LEDR[9:0].
//   clk_clk        in   system clock (same as soc_system)
//   reset_reset_n  in   asynchronous active-low reset
//   pio_cmd_i      in   [9:8] mode, [7:0] arg
//   led_o          out  registered LED drive, 1 = on
//   cmd_update_o   out  one-cycle pulse when a new command is accepted
//
// Mode state is cmd_q[9:8]; it only moves when the command changes.
//   state    | meaning
//   M_DIRECT | led = arg
//   M_BLINK  | led = arg while phase is 1, off otherwise; phase flips every BLINK_TICKS ticks
//   M_CHASE  | one-hot pos, rotated left every arg+1 ticks
//   M_PWM    | all LEDs on while the free-running 8-bit pwm count is below arg
module led_pio_sequencer
   import led_seq_pkg::*;
#(
   parameter int TICK_DIV    = 500000,
   parameter int BLINK_TICKS = 25
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [CMD_W-1:0] pio_cmd_i,
   output logic [LED_W-1:0] led_o,
   output logic             cmd_update_o
);

   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_TICKS - 1);

   logic [CMD_W-1:0] cmd_q;
   logic             cmd_update_q;
   logic             chg;
   logic             tick;
   led_mode_t        mode;
   logic [7:0]       arg;

   logic             phase_q, phase_d;
   logic [BW-1:0]    bcnt_q, bcnt_d;
   logic [LED_W-1:0] pos_q, pos_d;
   logic [7:0]       scnt_q, scnt_d;
   logic [7:0]       pwm_cnt_q, pwm_cnt_d;
   logic [LED_W-1:0] led_q, led_d;

   assign chg  = (pio_cmd_i != cmd_q);
   assign mode = led_mode_t'(cmd_q[MODE_MSB:MODE_LSB]);
   assign arg  = cmd_q[ARG_MSB:0];

   led_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .clr_i         (chg),
      .tick_o        (tick)
   );

   // A command change restarts every pattern and takes priority over any
   // tick landing in the same cycle.
   always_comb begin
      phase_d = phase_q;
      bcnt_d  = bcnt_q;
      if (chg) begin
         phase_d = 1'b1;
         bcnt_d  = '0;
      end else if (tick) begin
         if (bcnt_q == BLINK_TC) begin
            phase_d = ~phase_q;
            bcnt_d  = '0;
         end else begin
            bcnt_d = bcnt_q + BW'(1);
         end
      end
   end

   always_comb begin
      pos_d  = pos_q;
      scnt_d = scnt_q;
      if (chg) begin
         pos_d  = LED_W'(1);
         scnt_d = '0;
      end else if (tick) begin
         if (scnt_q == arg) begin
            pos_d  = rotl1(pos_q);
            scnt_d = '0;
         end else begin
            scnt_d = scnt_q + 8'd1;
         end
      end
   end

   assign pwm_cnt_d = chg ? 8'd0 : pwm_cnt_q + 8'd1;

   // Output decode uses the already-registered command, which gives the
   // one-edge pipeline between command capture and LED update.
   always_comb begin
      led_d = '0;
      case (mode)
         M_DIRECT: led_d = {2'b00, arg};
         M_BLINK:  led_d = phase_q ? {2'b00, arg} : '0;
         M_CHASE:  led_d = pos_q;
         M_PWM:    led_d = {LED_W{pwm_cnt_q < arg}};
         default:  led_d = '0;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         cmd_q        <= '0;
         cmd_update_q <= 1'b0;
      end else begin
         cmd_q        <= pio_cmd_i;
         cmd_update_q <= chg;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         phase_q <= 1'b1;
         bcnt_q  <= '0;
      end else begin
         phase_q <= phase_d;
         bcnt_q  <= bcnt_d;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         pos_q  <= LED_W'(1);
         scnt_q <= '0;
      end else begin
         pos_q  <= pos_d;
         scnt_q <= scnt_d;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         pwm_cnt_q <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         led_q <= '0;
      end else begin
         led_q <= led_d;
      end
   end

   assign led_o        = led_q;
   assign cmd_update_o = cmd_update_q;

endmodule

// File: tb/tb_led_pio_sequencer.sv
module tb_led_pio_sequencer;

   logic       clk_clk;
   logic       reset_reset_n;
   logic [9:0] pio_cmd_i;
   logic [9:0] led_o;
   logic       cmd_update_o;

   int checks   = 0;
   int failures = 0;

   // Each entry is {cmd_update_o, led_o} expected after one more rising edge.
   logic [10:0] exp_q[$];

   led_pio_sequencer #(
      .TICK_DIV    (4),
      .BLINK_TICKS (2)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .pio_cmd_i     (pio_cmd_i),
      .led_o         (led_o),
      .cmd_update_o  (cmd_update_o)
   );

   initial clk_clk = 1'b0;
   always #5 clk_clk = ~clk_clk;

   task automatic step();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic upd, input logic [9:0] led, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({upd, led});
   endtask

   task automatic run(input string tag);
      logic [10:0] e;
      while (exp_q.size() > 0) begin
         step();
         e = exp_q.pop_front();
         check(tag, {cmd_update_o, led_o}, e);
      end
   endtask

   // Drive a new command; the edge that samples it must raise cmd_update_o.
   task automatic send(input logic [9:0] cmd);
      pio_cmd_i = cmd;
      step();
      check("upd_pulse", {10'd0, cmd_update_o}, 11'd1);
   endtask

   initial begin
      logic [9:0] v;
      reset_reset_n = 1'b0;
      pio_cmd_i     = 10'h000;
      #22;
      check("reset_state", {cmd_update_o, led_o}, 11'h000);
      reset_reset_n = 1'b1;

      // 1: chase for 20 edges, then asynchronous reset mid-cycle
      send(10'h201);
      push(1'b0, 10'h001, 8);
      push(1'b0, 10'h002, 8);
      push(1'b0, 10'h004, 3);
      run("pre_reset_chase");
      #3;
      reset_reset_n = 1'b0;
      #1;
      check("async_reset", {cmd_update_o, led_o}, 11'h000);
      pio_cmd_i = 10'h000;
      step();
      #3;
      reset_reset_n = 1'b1;
      push(1'b0, 10'h000, 10);
      run("post_reset_idle");

      // 2: direct mode, single-cycle update pulse, two-edge latency
      send(10'h0A5);
      push(1'b0, 10'h0A5, 4);
      run("direct");

      // 3: blink, 8 on / 8 off; arg 0 stays dark
      send(10'h10F);
      push(1'b0, 10'h00F, 8);
      push(1'b0, 10'h000, 8);
      push(1'b0, 10'h00F, 8);
      push(1'b0, 10'h000, 8);
      run("blink");
      send(10'h100);
      push(1'b0, 10'h000, 20);
      run("blink_arg0");

      // 4: chase, arg 1 -> 8 cycles per step with wrap; arg 0 -> 4 cycles
      send(10'h201);
      for (int i = 0; i < 11; i++) begin
         v = 10'b1 << (i % 10);
         push(1'b0, v, 8);
      end
      run("chase_arg1");
      send(10'h200);
      for (int i = 0; i < 11; i++) begin
         v = 10'b1 << (i % 10);
         push(1'b0, v, 4);
      end
      run("chase_arg0");

      // 5: PWM duty 64/256, 0/256, 255/256
      send(10'h340);
      push(1'b0, 10'h3FF, 64);
      push(1'b0, 10'h000, 192);
      push(1'b0, 10'h3FF, 64);
      run("pwm_64");
      send(10'h300);
      push(1'b0, 10'h000, 256);
      run("pwm_0");
      send(10'h3FF);
      push(1'b0, 10'h3FF, 255);
      push(1'b0, 10'h000, 1);
      push(1'b0, 10'h3FF, 10);
      run("pwm_255");

      // 6: command change in blink off-phase, coincident with a tick
      send(10'h101);
      push(1'b0, 10'h001, 8);
      push(1'b0, 10'h000, 3);
      run("blink_pre_chg");
      send(10'h103);
      check("chg_edge_led", {1'b0, led_o}, 11'h000);
      push(1'b0, 10'h003, 8);
      push(1'b0, 10'h000, 8);
      push(1'b0, 10'h003, 4);
      run("blink_chg_tick");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
